// File: rtl/sram_dma_pkg.sv
// Shared types and constants for the SRAM block-move initiator.
// The optional perf counters are enabled with SRAM_DMA_PERF_EN.
package sram_dma_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD       = 2'd1,
    RD_DRAIN = 2'd2,
    WR       = 2'd3
  } dma_state_e;

  localparam logic [3:0] WEB_IDLE = 4'hF;
  localparam logic [3:0] WEB_WORD = 4'h0;

  localparam int unsigned LEN_W_DEF = 16;

  // First byte address past the SRAM; a command's end address may equal but not exceed it.
  localparam logic [33:0] SRAM_ADDR_HI_ZERO = 34'h0_0001_0000;

  function automatic logic span_exceeds(input logic [31:0] addr,
                                        input logic [33:0] len_bytes,
                                        input logic [33:0] limit);
    return ({2'b00, addr} + len_bytes) > limit;
  endfunction

endpackage

// File: rtl/sram_dma_skid_fifo.sv
// Two-entry 32-bit skid FIFO buffering SRAM read data toward the read stream.
// Push and pop may happen in the same cycle, including when full.
module sram_dma_skid_fifo (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic [31:0] wdata_i,
  input  logic        pop_i,
  output logic [31:0] rdata_o,
  output logic        valid_o,
  output logic [1:0]  count_o
);

  logic [31:0] mem_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic        do_push;
  logic        do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/sram_dma_master.sv
// Block-move initiator between valid/ready word streams and a single-port SRAM with
// one-cycle read latency. Define SRAM_DMA_PERF_EN to add busy/stall cycle counters.
module sram_dma_master
  import sram_dma_pkg::*;
#(
  parameter int unsigned LEN_W      = LEN_W_DEF,
  parameter logic [33:0] SRAM_BYTES = SRAM_ADDR_HI_ZERO
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             s_wvalid,
  output logic             s_wready,
  input  logic [31:0]      s_wdata,
  output logic             m_rvalid,
  input  logic             m_rready,
  output logic [31:0]      m_rdata,
  output logic [3:0]       sram_web,
  output logic [31:0]      sram_addr,
  output logic [31:0]      sram_wdata,
  input  logic [31:0]      sram_rdata,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef SRAM_DMA_PERF_EN
  ,
  output logic [31:0]      perf_busy_cyc,
  output logic [31:0]      perf_stall_cyc
`endif
);

  dma_state_e       state_q, state_d;
  logic [31:0]      cur_q, cur_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             inflight_q;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       fifo_count;
  logic             fifo_pop;
  logic             cmd_fire;
  logic             cmd_bad;
  logic             wr_beat;
  logic             rd_issue;
  logic [2:0]       rd_credit;

  assign cmd_ready = (state_q == IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign cmd_bad   = (cmd_len == '0) || (cmd_addr[1:0] != 2'b00)
                  || span_exceeds(cmd_addr, 34'({cmd_len, 2'b00}), SRAM_BYTES);

  assign s_wready = (state_q == WR);
  assign wr_beat  = s_wvalid && s_wready;
  assign fifo_pop = m_rvalid && m_rready;

  // The word leaving the FIFO this cycle frees a slot, so steady m_rready sustains one word per cycle.
  assign rd_credit = {1'b0, fifo_count} - {2'b00, fifo_pop} + {2'b00, inflight_q};
  assign rd_issue  = (state_q == RD) && (rd_credit < 3'd2);

  assign sram_web   = wr_beat ? WEB_WORD : WEB_IDLE;
  assign sram_addr  = cur_q;
  assign sram_wdata = wr_beat ? s_wdata : '0;

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err  = err_q;

  sram_dma_skid_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .wdata_i (sram_rdata),
    .pop_i   (fifo_pop),
    .rdata_o (m_rdata),
    .valid_o (m_rvalid),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            cur_d   = cmd_addr;
            rem_d   = cmd_len;
            state_d = cmd_write ? WR : RD;
          end
        end
      end
      RD: begin
        if (rd_issue) begin
          cur_d = cur_q + 32'd4;
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if ((fifo_count == 2'd0) && !inflight_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      WR: begin
        if (wr_beat) begin
          cur_d = cur_q + 32'd4;
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      rem_q      <= rem_d;
      inflight_q <= rd_issue;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

`ifdef SRAM_DMA_PERF_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_stall_q;
  logic        stall_now;

  assign stall_now      = ((state_q == WR) && !s_wvalid) || (m_rvalid && !m_rready);
  assign perf_busy_cyc  = perf_busy_q;
  assign perf_stall_cyc = perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else if (cmd_fire) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + 32'd1;
      if (stall_now && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_dma_master.sv
// Directed bench for sram_dma_master with a 1-cycle-latency SRAM model and a shadow memory.
module tb_sram_dma_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic        m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic [3:0]  sram_web;
  logic [31:0] sram_addr, sram_wdata;
  logic [31:0] sram_rdata = '0;
  logic        busy, done, err;
`ifdef SRAM_DMA_PERF_EN
  logic [31:0] perf_busy_cyc, perf_stall_cyc;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem    [0:16383];
  logic [31:0] shadow [0:16383];

  always #5 clk = ~clk;

  sram_dma_master dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .s_wvalid   (s_wvalid),
    .s_wready   (s_wready),
    .s_wdata    (s_wdata),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready),
    .m_rdata    (m_rdata),
    .sram_web   (sram_web),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef SRAM_DMA_PERF_EN
    ,
    .perf_busy_cyc  (perf_busy_cyc),
    .perf_stall_cyc (perf_stall_cyc)
`endif
  );

  // SRAM model: synchronous write, registered read.
  always @(posedge clk) begin
    if (sram_web == 4'h0) mem[sram_addr[15:2]] <= sram_wdata;
    sram_rdata <= mem[sram_addr[15:2]];
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && sram_web !== 4'h0 && sram_web !== 4'hF) begin
      n_fail++;
      $display("FAIL web_partial: got %h required 0 or f", sram_web);
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [15:0] len;
    int          mode;       // 0 steady, 1 toggle valid/ready, 2 ready held off 5 cycles
    logic        exp_err;
    int          exp_first;  // loop cycle of first beat, -1 when not checked
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [15:0] len,
                         input int mode, input logic exp_err, output int first_beat);
    int k;
    int it;
    int w;
    logic [31:0] a;
    first_beat = -1;
    k  = 0;
    it = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    #1 chk("cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (exp_err) begin
      s_wvalid = 1'b1; s_wdata = 32'hDEAD_BEEF; m_rready = 1'b1;
      #1;
      chk("err_pulse", {31'b0, err}, 32'd1);
      chk("err_busy", {31'b0, busy}, 32'd0);
      chk("err_web", {28'b0, sram_web}, 32'hF);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk); #1;
        chk("err_single", {31'b0, err}, 32'd0);
        chk("err_no_done", {31'b0, done}, 32'd0);
        chk("err_web_idle", {28'b0, sram_web}, 32'hF);
      end
      s_wvalid = 1'b0; m_rready = 1'b0;
    end else begin
      while (k < int'(len) && it < 400) begin
        a = addr + 32'(4 * k);
        if (wr) begin
          s_wvalid = (mode == 1) ? ~it[0] : 1'b1;
          s_wdata  = 32'hA000_0000 + a;
        end else begin
          m_rready = (mode == 1) ? ~it[0] : (mode == 2) ? (it >= 5) : 1'b1;
        end
        #1;
        if (wr) begin
          chk("wr_sready", {31'b0, s_wready}, 32'd1);
          if (s_wvalid) begin
            if (first_beat < 0) first_beat = it;
            chk("wr_web", {28'b0, sram_web}, 32'h0);
            chk("wr_addr", sram_addr, a);
            chk("wr_data", sram_wdata, 32'hA000_0000 + a);
            shadow[a[15:2]] = 32'hA000_0000 + a;
            k++;
          end else begin
            chk("wr_gap_web", {28'b0, sram_web}, 32'hF);
          end
        end else begin
          chk("rd_web", {28'b0, sram_web}, 32'hF);
          if (m_rvalid && m_rready) begin
            if (first_beat < 0) first_beat = it;
            chk("rd_data", m_rdata, shadow[a[15:2]]);
            k++;
          end
        end
        @(negedge clk);
        it++;
      end
      s_wvalid = 1'b0; m_rready = 1'b0;
      chk("beats", 32'(k), 32'(len));
      #1;
      if (!wr) begin
        w = 0;
        while (!done && w < 10) begin
          @(negedge clk); #1;
          w++;
        end
      end
      chk("done", {31'b0, done}, 32'd1);
      chk("done_busy", {31'b0, busy}, 32'd0);
      @(negedge clk); #1;
      chk("done_single", {31'b0, done}, 32'd0);
    end
    $display("[TB] cmd wr=%0d addr=%h len=%0d mode=%0d err=%0d first_beat=%0d",
             wr, addr, len, mode, exp_err, first_beat);
  endtask

  initial begin
    int fb;
    for (int i = 0; i < 16384; i++) begin
      mem[i]    = 32'h5A00_0000 | 32'(i);
      shadow[i] = 32'h5A00_0000 | 32'(i);
    end
    tbl[0] = '{1'b1, 32'h0000_0100, 16'd4, 0, 1'b0, 0};
    tbl[1] = '{1'b0, 32'h0000_0100, 16'd4, 0, 1'b0, 2};
    tbl[2] = '{1'b1, 32'h0000_0200, 16'd8, 1, 1'b0, 0};
    tbl[3] = '{1'b0, 32'h0000_0200, 16'd8, 1, 1'b0, 2};
    tbl[4] = '{1'b0, 32'h0000_FFF8, 16'd2, 0, 1'b0, 2};
    tbl[5] = '{1'b1, 32'h0000_FFFC, 16'd2, 0, 1'b1, -1};
    tbl[6] = '{1'b0, 32'h0000_0102, 16'd1, 0, 1'b1, -1};
    tbl[7] = '{1'b1, 32'h0000_0000, 16'd0, 0, 1'b1, -1};
    tbl[8] = '{1'b0, 32'h0000_0000, 16'd3, 2, 1'b0, 5};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    s_wvalid = 1'b0; s_wdata = '0; m_rready = 1'b0;
    #1;
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_s_wready", {31'b0, s_wready}, 32'd0);
    chk("rst_m_rvalid", {31'b0, m_rvalid}, 32'd0);
    chk("rst_m_rdata", m_rdata, 32'd0);
    chk("rst_web", {28'b0, sram_web}, 32'hF);
    chk("rst_addr", sram_addr, 32'd0);
    chk("rst_wdata", sram_wdata, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      run_cmd(tbl[v].wr, tbl[v].addr, tbl[v].len, tbl[v].mode, tbl[v].exp_err, fb);
      if (tbl[v].exp_first >= 0) chk("first_beat", 32'(fb), 32'(tbl[v].exp_first));
    end

    // Reset while a read has filled the skid FIFO, then a clean rerun.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h200; cmd_len = 16'd8;
    @(negedge clk);
    cmd_valid = 1'b0; m_rready = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("pre_rst_rvalid", {31'b0, m_rvalid}, 32'd1);
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", {31'b0, m_rvalid}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("mid_rst_web", {28'b0, sram_web}, 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset asserted mid-read");
    run_cmd(1'b0, 32'h200, 16'd8, 0, 1'b0, fb);
    chk("post_rst_first", 32'(fb), 32'd2);

`ifdef SRAM_DMA_PERF_EN
    run_cmd(1'b0, 32'h300, 16'd4, 2, 1'b0, fb);
    chk("perf_stall", perf_stall_cyc, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

endmodule
